// File: rtl/approx_adder_err_monitor_if.sv
// approx_adder_err_monitor_if: sample stream, window control and statistics bus of the error monitor
interface approx_adder_err_monitor_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [OP_W-1:0]  approx_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] err_sum;
    logic [OP_W-1:0]  err_max;
    logic [ACC_W-1:0] hd_sum;
`ifdef WORST_CASE_CAPTURE_EN
    logic [OP_W-1:0]  wc_op_a;
    logic [OP_W-1:0]  wc_op_b;
    logic [OP_W-1:0]  wc_approx;
    modport master (
        output start, num_samples, in_valid, op_a, op_b, approx_sum,
        input  in_ready, busy, done, err_count, err_sum, err_max, hd_sum, wc_op_a, wc_op_b, wc_approx
    );
    modport slave (
        input  start, num_samples, in_valid, op_a, op_b, approx_sum,
        output in_ready, busy, done, err_count, err_sum, err_max, hd_sum, wc_op_a, wc_op_b, wc_approx
    );
`else
    modport master (
        output start, num_samples, in_valid, op_a, op_b, approx_sum,
        input  in_ready, busy, done, err_count, err_sum, err_max, hd_sum
    );
    modport slave (
        input  start, num_samples, in_valid, op_a, op_b, approx_sum,
        output in_ready, busy, done, err_count, err_sum, err_max, hd_sum
    );
`endif
endinterface

// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: scores an approximate adder over a sample window (count, abs sum, max, Hamming sum).
// Optional WORST_CASE_CAPTURE_EN adds capture of the sample that set err_max.
module approx_adder_err_monitor #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input logic clk,
    input logic rst,
    approx_adder_err_monitor_if.slave bus
);
    localparam int SW = (ACC_W > OP_W ? ACC_W : OP_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state;
    logic             r_in_ready, r_busy, r_done, r_s1_v, r_first;
    logic [CNT_W-1:0] r_rem, r_err_count;
    logic [OP_W-1:0]  r_s1_exact, r_s1_approx, r_err_max;
    logic [ACC_W-1:0] r_err_sum, r_hd_sum;
    logic             w_acc, w_start;
    logic [OP_W-1:0]  w_x, w_diff, w_hd;
    logic [SW-1:0]    w_es, w_hs;

    assign w_start = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_acc   = bus.in_valid && r_in_ready;
    assign w_x     = r_s1_exact ^ r_s1_approx;
    assign w_diff  = r_s1_exact >= r_s1_approx ? r_s1_exact - r_s1_approx : r_s1_approx - r_s1_exact;
    assign w_hd    = OP_W'($countones(w_x));
    // one spare bit above the accumulator exposes the carry used for saturation
    assign w_es    = SW'(r_err_sum) + SW'(w_diff);
    assign w_hs    = SW'(r_hd_sum) + SW'(w_hd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rem      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (bus.start) begin
                    r_state    <= RUN;
                    r_rem      <= bus.num_samples == '0 ? CNT_W'(1) : bus.num_samples;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b1;
                    r_done     <= 1'b0;
                end
                RUN: if (w_acc) begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        r_state    <= DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                DRAIN: if (!r_s1_v) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

`ifdef WORST_CASE_CAPTURE_EN
    logic [OP_W-1:0] r_s1_a, r_s1_b, r_wc_a, r_wc_b, r_wc_x;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_a <= '0;
            r_s1_b <= '0;
            r_wc_a <= '0;
            r_wc_b <= '0;
            r_wc_x <= '0;
        end else begin
            if (w_acc) begin
                r_s1_a <= bus.op_a;
                r_s1_b <= bus.op_b;
            end
            if (w_start) begin
                r_wc_a <= '0;
                r_wc_b <= '0;
                r_wc_x <= '0;
            end else if (r_s1_v && (r_first || w_diff > r_err_max)) begin
                r_wc_a <= r_s1_a;
                r_wc_b <= r_s1_b;
                r_wc_x <= r_s1_approx;
            end
        end
    end
    assign bus.wc_op_a   = r_wc_a;
    assign bus.wc_op_b   = r_wc_b;
    assign bus.wc_approx = r_wc_x;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_first     <= 1'b0;
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
            r_hd_sum    <= '0;
        end else begin
            r_s1_v <= w_acc;
            if (w_acc) begin
                r_s1_exact  <= bus.op_a + bus.op_b;
                r_s1_approx <= bus.approx_sum;
            end
            if (w_start) begin
                r_first     <= 1'b1;
                r_err_count <= '0;
                r_err_sum   <= '0;
                r_err_max   <= '0;
                r_hd_sum    <= '0;
            end else if (r_s1_v) begin
                r_first     <= 1'b0;
                r_err_count <= w_diff != '0 ? r_err_count + 1'b1 : r_err_count;
                r_err_sum   <= |w_es[SW-1:ACC_W] ? '1 : w_es[ACC_W-1:0];
                r_hd_sum    <= |w_hs[SW-1:ACC_W] ? '1 : w_hs[ACC_W-1:0];
                r_err_max   <= w_diff > r_err_max ? w_diff : r_err_max;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err_count = r_err_count;
    assign bus.err_sum   = r_err_sum;
    assign bus.err_max   = r_err_max;
    assign bus.hd_sum    = r_hd_sum;
endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb_approx_adder_err_monitor: randomized windows scored against a per-window arithmetic model; a 4-bit-accumulator twin checks saturation
module tb_approx_adder_err_monitor;
    localparam int OP_W = 6, CNT_W = 16, ACC_W = 24, SAT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_adder_err_monitor_if #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) mif ();
    approx_adder_err_monitor_if #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(SAT_W)) sif ();

    assign sif.start       = mif.start;
    assign sif.num_samples = mif.num_samples;
    assign sif.in_valid    = mif.in_valid;
    assign sif.op_a        = mif.op_a;
    assign sif.op_b        = mif.op_b;
    assign sif.approx_sum  = mif.approx_sum;

    approx_adder_err_monitor #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(mif.slave));
    approx_adder_err_monitor #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(SAT_W)) dut_sat (.clk(clk), .rst(rst), .bus(sif.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int qa[$], qb[$], qx[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int a, input int b, input int x);
        qa.push_back(a);
        qb.push_back(b);
        qx.push_back(x);
    endtask

    task automatic push_rand(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int a, b;
            a = $urandom_range(63);
            b = $urandom_range(63);
            push(a, b, ($urandom_range(3) == 0) ? (a + b) % 64 : $urandom_range(63));
        end
    endtask

    // Runs one window over the queued samples; the first max(num,1) presented during RUN count.
    task automatic run_window(input int num, input int gap, input bit hold_valid, input bit mid_start, input bit chk_lat);
        int n, acc, sent, last, e_cnt, e_max, d, ex, hd, wa, wb, wx;
        longint s_abs, s_hd;
        bit timeout;
        n = (num == 0) ? 1 : num;
        e_cnt = 0; e_max = 0; s_abs = 0; s_hd = 0; wa = 0; wb = 0; wx = 0;
        for (int i = 0; i < n; i++) begin
            ex = (qa[i] + qb[i]) % 64;
            d = (ex >= qx[i]) ? ex - qx[i] : qx[i] - ex;
            hd = 0;
            for (int k = 0; k < OP_W; k++) hd += ((ex ^ qx[i]) >> k) & 1;
            e_cnt += (d != 0);
            s_abs += d;
            s_hd += hd;
            if (i == 0 || d > e_max) begin
                e_max = d; wa = qa[i]; wb = qb[i]; wx = qx[i];
            end
        end
        mif.num_samples = CNT_W'(num);
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        n_cmp++;
        if (mif.busy !== 1'b1 || mif.done !== 1'b0) begin
            n_bad++;
            $display("FAIL window_start: busy=%b done=%b, want busy=1 done=0", mif.busy, mif.done);
        end
        acc = 0; sent = 0; last = cyc;
        while (sent < qa.size()) begin
            mif.in_valid = 1'b1;
            mif.op_a = OP_W'(qa[sent]);
            mif.op_b = OP_W'(qb[sent]);
            mif.approx_sum = OP_W'(qx[sent]);
            if (mid_start && sent == 1) begin
                mif.start = 1'b1;
                mif.num_samples = CNT_W'(1);
            end
            n_cmp++;
            if (mif.in_ready !== (acc < n)) begin
                n_bad++;
                $display("FAIL in_ready_run: sample %0d got %b want %b", sent, mif.in_ready, acc < n);
            end
            tick();
            mif.start = 1'b0;
            if (acc < n) begin
                acc++;
                last = cyc;
            end
            sent++;
            if (sent < qa.size())
                for (int g = 0; g < gap; g++) begin
                    mif.in_valid = 1'b0;
                    tick();
                end
        end
        mif.in_valid = hold_valid;
        timeout = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (mif.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL in_ready_drain: got %b want 0", mif.in_ready);
            end
            if (chk_lat && cyc - last == 1) begin
                n_cmp++;
                if (mif.err_count !== CNT_W'(e_cnt)) begin
                    n_bad++;
                    $display("FAIL stats_t_plus_2: err_count got %0d want %0d", mif.err_count, e_cnt);
                end
            end
            if (mif.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        n_cmp++;
        if (timeout) begin
            n_bad++;
            $display("FAIL done_timeout: done still %b after 10 cycles, want 1", mif.done);
        end
        if (chk_lat) begin
            n_cmp++;
            if (cyc - last != 2) begin
                n_bad++;
                $display("FAIL done_latency: got %0d cycles after accept, want 3", cyc - last + 1);
            end
        end
        mif.in_valid = 1'b0;
        n_cmp++;
        if (mif.err_count !== CNT_W'(e_cnt)) begin
            n_bad++;
            $display("FAIL err_count: got %0d want %0d", mif.err_count, e_cnt);
        end
        n_cmp++;
        if (mif.err_sum !== ACC_W'(s_abs > 64'hFFFFFF ? 64'hFFFFFF : s_abs)) begin
            n_bad++;
            $display("FAIL err_sum: got %0d want %0d", mif.err_sum, s_abs);
        end
        n_cmp++;
        if (mif.err_max !== OP_W'(e_max)) begin
            n_bad++;
            $display("FAIL err_max: got %0d want %0d", mif.err_max, e_max);
        end
        n_cmp++;
        if (mif.hd_sum !== ACC_W'(s_hd > 64'hFFFFFF ? 64'hFFFFFF : s_hd)) begin
            n_bad++;
            $display("FAIL hd_sum: got %0d want %0d", mif.hd_sum, s_hd);
        end
        n_cmp++;
        if (sif.err_sum !== SAT_W'(s_abs > 15 ? 15 : s_abs) || sif.hd_sum !== SAT_W'(s_hd > 15 ? 15 : s_hd)
            || sif.err_count !== CNT_W'(e_cnt)) begin
            n_bad++;
            $display("FAIL sat_twin: err_sum=%0d hd_sum=%0d err_count=%0d want %0d %0d %0d", sif.err_sum, sif.hd_sum,
                     sif.err_count, s_abs > 15 ? 15 : s_abs, s_hd > 15 ? 15 : s_hd, e_cnt);
        end
`ifdef WORST_CASE_CAPTURE_EN
        n_cmp++;
        if (mif.wc_op_a !== OP_W'(wa) || mif.wc_op_b !== OP_W'(wb) || mif.wc_approx !== OP_W'(wx)) begin
            n_bad++;
            $display("FAIL worst_case: got %0d,%0d,%0d want %0d,%0d,%0d", mif.wc_op_a, mif.wc_op_b, mif.wc_approx, wa, wb, wx);
        end
`endif
        qa.delete();
        qb.delete();
        qx.delete();
    endtask

    task automatic test_reset();
        mif.start = 1'b0; mif.in_valid = 1'b0; mif.num_samples = '0;
        mif.op_a = '0; mif.op_b = '0; mif.approx_sum = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mif.in_valid = 1'b1;
        mif.op_a = 6'd9;
        mif.approx_sum = 6'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({mif.in_ready, mif.busy, mif.done} !== 3'b000 || mif.err_count !== '0 || mif.err_sum !== '0
                || mif.err_max !== '0 || mif.hd_sum !== '0) begin
                n_bad++;
                $display("FAIL reset_idle: rdy/busy/done=%b%b%b cnt=%0d sum=%0d max=%0d hd=%0d, want all 0",
                         mif.in_ready, mif.busy, mif.done, mif.err_count, mif.err_sum, mif.err_max, mif.hd_sum);
            end
        end
        mif.in_valid = 1'b0;
    endtask

    task automatic test_exact_feed();
        push(3, 5, 8); push(63, 1, 0); push(20, 20, 40); push(0, 0, 0);
        run_window(4, 0, 0, 0, 1);
    endtask

    task automatic test_single_error();
        push(10, 7, 16);
        run_window(1, 0, 0, 0, 1);
    endtask

    task automatic test_wrap_abs();
        push(60, 10, 0); push(1, 1, 9);
        run_window(2, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] held;
        push_rand(5);
        run_window(5, 3, 1, 0, 0);
        held = mif.err_count;
        mif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (mif.done !== 1'b1 || mif.in_ready !== 1'b0 || mif.err_count !== held) begin
                n_bad++;
                $display("FAIL done_hold: done=%b in_ready=%b cnt=%0d want 1 0 %0d", mif.done, mif.in_ready, mif.err_count, held);
            end
        end
        mif.in_valid = 1'b0;
    endtask

    task automatic test_zero_len();
        push_rand(4);
        run_window(0, 0, 1, 0, 0);
    endtask

    task automatic test_saturation();
        push(0, 0, 7); push(0, 0, 7); push(0, 0, 7);
        run_window(3, 0, 0, 0, 1);
    endtask

    task automatic test_start_ignored();
        push_rand(3);
        run_window(3, 0, 0, 1, 1);
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 3; w++) begin
            push_rand(2 + w);
            run_window(2 + w, 0, 0, 0, 1);
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            int n;
            n = $urandom_range(20, 1);
            push_rand(n + $urandom_range(2));
            run_window(n, $urandom_range(2), $urandom_range(1), 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        mif.num_samples = CNT_W'(4);
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        mif.in_valid = 1'b1;
        mif.op_a = 6'd5; mif.op_b = 6'd5; mif.approx_sum = 6'd60;
        tick();
        mif.op_a = 6'd30; mif.op_b = 6'd2; mif.approx_sum = 6'd1;
        tick();
        mif.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({mif.in_ready, mif.busy, mif.done} !== 3'b000 || mif.err_count !== '0 || mif.err_sum !== '0
                || mif.err_max !== '0 || mif.hd_sum !== '0) begin
                n_bad++;
                $display("FAIL reset_mid: rdy/busy/done=%b%b%b cnt=%0d sum=%0d max=%0d hd=%0d, want all 0",
                         mif.in_ready, mif.busy, mif.done, mif.err_count, mif.err_sum, mif.err_max, mif.hd_sum);
            end
            tick();
        end
        push(12, 13, 25);
        run_window(1, 0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_exact_feed();
        test_single_error();
        test_wrap_abs();
        test_backpressure();
        test_zero_len();
        test_saturation();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
